// File: rtl/rf_2p_lane_if.sv
// Bus bundle for the rf_2p_lane register file: clear/busy control, read
// request/response and masked write request. The master side drives the
// i_* requests and the slave side (the register file) drives the o_* responses.
interface rf_2p_lane_if #(
  parameter int WORDWD = 32,
  parameter int DWD    = 32,
  parameter int LANEWD = 16,
  parameter int SIZE   = 1
);
  localparam int AWD   = $clog2(WORDWD);
  localparam int NLANE = DWD / LANEWD;

  logic                      i_clear;
  logic                      o_busy;
  logic                      i_read;
  logic [AWD-1:0]            i_raddr;
  logic                      o_rvalid;
  logic [SIZE-1:0][DWD-1:0]  o_rdata;
  logic                      i_write;
  logic [AWD-1:0]            i_waddr;
  logic [NLANE-1:0]          i_wmsk;
  logic [SIZE-1:0][DWD-1:0]  i_wdata;

  modport master (
    output i_clear, i_read, i_raddr, i_write, i_waddr, i_wmsk, i_wdata,
    input  o_busy, o_rvalid, o_rdata
  );

  modport slave (
    input  i_clear, i_read, i_raddr, i_write, i_waddr, i_wmsk, i_wdata,
    output o_busy, o_rvalid, o_rdata
  );
endinterface

// File: rtl/rf_2p_lane.sv
// rf_2p_lane: parametrised 1R/1W register file with SIZE parallel channels
// sharing one address pair, per-lane write mask, a hardware clear sequencer
// (after reset or on i_clear), out-of-range address protection and a
// 1- or 2-cycle registered read path with a valid strobe.
// Optional macro RF_2P_BYPASS_EN: when defined, a same-cycle same-address
// read returns the write-first merged word; when undefined it returns the
// old word (read-first). Either way the write commits normally.
module rf_2p_lane #(
  parameter int WORDWD = 32,
  parameter int DWD    = 32,
  parameter int LANEWD = 16,
  parameter int SIZE   = 1,
  parameter int RDLAT  = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  rf_2p_lane_if.slave   io_bus
);
  localparam int NLANE = DWD / LANEWD;
  localparam int AWD   = $clog2(WORDWD);

  // Illegal geometries are rejected at elaboration.
  generate
    if (RDLAT != 1 && RDLAT != 2) begin : g_badRdlat
      $error("rf_2p_lane: RDLAT must be 1 or 2");
    end
    if ((DWD % LANEWD) != 0) begin : g_badLane
      $error("rf_2p_lane: DWD must be a multiple of LANEWD");
    end
    if (WORDWD < 2) begin : g_badDepth
      $error("rf_2p_lane: WORDWD must be at least 2");
    end
  endgenerate

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_stateNext;
  logic [AWD-1:0]            r_cnt;
  logic [AWD-1:0]            w_cntNext;
  logic                      w_clrWe;
  logic                      w_busy;

  logic [SIZE-1:0][DWD-1:0]  r_mem [WORDWD];

  logic                      w_rdInRange;
  logic                      w_wrInRange;
  logic                      w_rdAcc;
  logic                      w_wrAcc;
  logic [SIZE-1:0][DWD-1:0]  w_rdRaw;
  logic [SIZE-1:0][DWD-1:0]  w_rdWord;

  logic                      r_vld1;
  logic [SIZE-1:0][DWD-1:0]  r_data1;

  assign w_busy        = (r_state == S_CLEAR);
  assign io_bus.o_busy = w_busy;

  assign w_rdInRange = (32'(io_bus.i_raddr) < 32'(WORDWD));
  assign w_wrInRange = (32'(io_bus.i_waddr) < 32'(WORDWD));
  assign w_rdAcc     = io_bus.i_read  & ~w_busy;
  assign w_wrAcc     = io_bus.i_write & ~w_busy & w_wrInRange;

  // Clear-sequencer state register; reset restarts the sweep from word 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Clear sweep writes one word per cycle and leaves after the last word.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_clrWe     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clrWe = 1'b1;
        if (r_cnt == AWD'(WORDWD - 1)) begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (io_bus.i_clear) begin
          w_stateNext = S_CLEAR;
          w_cntNext   = '0;
        end
      end
      default: begin
        w_stateNext = S_CLEAR;
        w_cntNext   = '0;
      end
    endcase
  end

  // Array update: clear sweep has priority (writes are blocked while busy anyway).
  always_ff @(posedge i_clk) begin
    if (i_rst && w_clrWe) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wrAcc) begin
      for (int ch = 0; ch < SIZE; ch++) begin
        for (int k = 0; k < NLANE; k++) begin
          if (io_bus.i_wmsk[k]) begin
            r_mem[io_bus.i_waddr][ch][k*LANEWD +: LANEWD] <= io_bus.i_wdata[ch][k*LANEWD +: LANEWD];
          end
        end
      end
    end
  end

  // Raw array read; out-of-range addresses read as zero instead of X.
  always_comb begin
    w_rdRaw = '0;
    if (w_rdInRange) begin
      w_rdRaw = r_mem[io_bus.i_raddr];
    end
  end

  // Same-address collision: optionally merge the incoming masked lanes.
  always_comb begin
    w_rdWord = w_rdRaw;
`ifdef RF_2P_BYPASS_EN
    if (w_wrAcc && (io_bus.i_waddr == io_bus.i_raddr)) begin
      for (int ch = 0; ch < SIZE; ch++) begin
        for (int k = 0; k < NLANE; k++) begin
          if (io_bus.i_wmsk[k]) begin
            w_rdWord[ch][k*LANEWD +: LANEWD] = io_bus.i_wdata[ch][k*LANEWD +: LANEWD];
          end
        end
      end
    end
`else
    w_rdWord = w_rdRaw;
`endif
  end

  // First read stage: capture the word at the acceptance edge, hold otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_vld1  <= 1'b0;
      r_data1 <= '0;
    end else begin
      r_vld1 <= w_rdAcc;
      if (w_rdAcc) begin
        r_data1 <= w_rdWord;
      end
    end
  end

  generate
    if (RDLAT == 2) begin : g_lat2
      logic                      r_vld2;
      logic [SIZE-1:0][DWD-1:0]  r_data2;

      // Second read stage: data and strobe move together, data holds when idle.
      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          r_vld2  <= 1'b0;
          r_data2 <= '0;
        end else begin
          r_vld2 <= r_vld1;
          if (r_vld1) begin
            r_data2 <= r_data1;
          end
        end
      end

      assign io_bus.o_rvalid = r_vld2;
      assign io_bus.o_rdata  = r_data2;
    end else begin : g_lat1
      assign io_bus.o_rvalid = r_vld1;
      assign io_bus.o_rdata  = r_data1;
    end
  endgenerate

endmodule

// File: tb/tb_rf_2p_lane.sv
// Testbench for rf_2p_lane. Three instances share one stimulus bus:
//   A: 32 words, 2 channels, RDLAT=1
//   B: 32 words, 2 channels, RDLAT=2
//   C: 20 words, 2 channels, RDLAT=1 (non power of two depth)
// Reads push their expected word and arrival time into a per-instance queue;
// a monitor pops and compares whenever an instance raises o_rvalid.
module tb_rf_2p_lane;

  logic clock = 1'b0;
  logic rstN;

  int              stimSel;
  logic            stimRead;
  logic [4:0]      stimRaddr;
  logic            stimWrite;
  logic [4:0]      stimWaddr;
  logic [1:0]      stimWmsk;
  logic [63:0]     stimWdata;
  logic            stimClear;

  int vecCnt = 0;
  int errCnt = 0;
  int negCnt = 0;
  int busyNeg [3];

  logic [95:0] qA [$];
  logic [95:0] qB [$];
  logic [95:0] qC [$];

  // Free-running clock.
  always #5 clock = ~clock;

  rf_2p_lane_if #(.WORDWD(32), .DWD(32), .LANEWD(16), .SIZE(2)) ifA ();
  rf_2p_lane_if #(.WORDWD(32), .DWD(32), .LANEWD(16), .SIZE(2)) ifB ();
  rf_2p_lane_if #(.WORDWD(20), .DWD(32), .LANEWD(16), .SIZE(2)) ifC ();

  assign ifA.i_clear = stimClear & (stimSel == 0);
  assign ifA.i_read  = stimRead  & (stimSel == 0);
  assign ifA.i_write = stimWrite & (stimSel == 0);
  assign ifA.i_raddr = stimRaddr;
  assign ifA.i_waddr = stimWaddr;
  assign ifA.i_wmsk  = stimWmsk;
  assign ifA.i_wdata = stimWdata;

  assign ifB.i_clear = stimClear & (stimSel == 1);
  assign ifB.i_read  = stimRead  & (stimSel == 1);
  assign ifB.i_write = stimWrite & (stimSel == 1);
  assign ifB.i_raddr = stimRaddr;
  assign ifB.i_waddr = stimWaddr;
  assign ifB.i_wmsk  = stimWmsk;
  assign ifB.i_wdata = stimWdata;

  assign ifC.i_clear = stimClear & (stimSel == 2);
  assign ifC.i_read  = stimRead  & (stimSel == 2);
  assign ifC.i_write = stimWrite & (stimSel == 2);
  assign ifC.i_raddr = stimRaddr;
  assign ifC.i_waddr = stimWaddr;
  assign ifC.i_wmsk  = stimWmsk;
  assign ifC.i_wdata = stimWdata;

  rf_2p_lane #(.WORDWD(32), .DWD(32), .LANEWD(16), .SIZE(2), .RDLAT(1)) dutA (
    .i_clk (clock), .i_rst (rstN), .io_bus (ifA.slave)
  );
  rf_2p_lane #(.WORDWD(32), .DWD(32), .LANEWD(16), .SIZE(2), .RDLAT(2)) dutB (
    .i_clk (clock), .i_rst (rstN), .io_bus (ifB.slave)
  );
  rf_2p_lane #(.WORDWD(20), .DWD(32), .LANEWD(16), .SIZE(2), .RDLAT(1)) dutC (
    .i_clk (clock), .i_rst (rstN), .io_bus (ifC.slave)
  );

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  function automatic logic busyOf(input int sel);
    case (sel)
      0:       return ifA.o_busy;
      1:       return ifB.o_busy;
      default: return ifC.o_busy;
    endcase
  endfunction

  task automatic popAndCheck(input int d, input logic [63:0] act);
    logic [95:0] e;
    logic got;
    got = 1'b0;
    e   = '0;
    case (d)
      0: if (qA.size() > 0) begin e = qA.pop_front(); got = 1'b1; end
      1: if (qB.size() > 0) begin e = qB.pop_front(); got = 1'b1; end
      default: if (qC.size() > 0) begin e = qC.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      vecCnt++;
      errCnt++;
      $display("[TB] FAIL unexpectedRvalid dut%0d: got rvalid=1 data %h, want no rvalid", d, act);
    end else begin
      checkOutput($sformatf("rdata dut%0d", d), act, e[63:0]);
      checkOutput($sformatf("rvalidTime dut%0d", d), 64'(negCnt), 64'(e[95:64]));
    end
  endtask

  // Monitor: compare every read response and count busy cycles per instance.
  initial begin
    busyNeg[0] = 0;
    busyNeg[1] = 0;
    busyNeg[2] = 0;
    forever begin
      @(negedge clock);
      if (ifA.o_rvalid) popAndCheck(0, ifA.o_rdata);
      if (ifB.o_rvalid) popAndCheck(1, ifB.o_rdata);
      if (ifC.o_rvalid) popAndCheck(2, ifC.o_rdata);
      if (ifA.o_busy) busyNeg[0]++;
      if (ifB.o_busy) busyNeg[1]++;
      if (ifC.o_busy) busyNeg[2]++;
      negCnt++;
    end
  end

  // One bus cycle of stimulus; a checked read queues its expected response.
  task automatic applyStimulus(input int sel, input logic rd, input logic [4:0] ra,
                               input logic wr, input logic [4:0] wa, input logic [1:0] msk,
                               input logic [63:0] wd, input logic expOn, input logic [63:0] expData);
    logic [31:0] due;
    @(posedge clock);
    #1;
    stimSel   = sel;
    stimRead  = rd;
    stimRaddr = ra;
    stimWrite = wr;
    stimWaddr = wa;
    stimWmsk  = msk;
    stimWdata = wd;
    stimClear = 1'b0;
    if (rd && expOn) begin
      due = 32'(negCnt + ((sel == 1) ? 2 : 1));
      case (sel)
        0:       qA.push_back({due, expData});
        1:       qB.push_back({due, expData});
        default: qC.push_back({due, expData});
      endcase
    end
  endtask

  task automatic doWrite(input int sel, input logic [4:0] a, input logic [1:0] msk, input logic [63:0] wd);
    applyStimulus(sel, 1'b0, 5'd0, 1'b1, a, msk, wd, 1'b0, 64'd0);
  endtask

  task automatic doRead(input int sel, input logic [4:0] a, input logic [63:0] exp);
    applyStimulus(sel, 1'b1, a, 1'b0, 5'd0, 2'b00, 64'd0, 1'b1, exp);
  endtask

  task automatic doIdle();
    applyStimulus(0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic doClear(input int sel);
    applyStimulus(sel, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 64'd0, 1'b0, 64'd0);
    stimClear = 1'b1;
  endtask

  task automatic waitIdle(input int sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (!busyOf(sel)) break;
    end
    checkOutput($sformatf("idleTimeout dut%0d", sel), 64'(busyOf(sel)), 64'd0);
  endtask

  // Directed test sequence.
  initial begin
    int b0, b1, b2;
    logic [63:0] collideExp;

    rstN = 1'b0;
    stimSel = 0; stimRead = 1'b0; stimRaddr = '0; stimWrite = 1'b0;
    stimWaddr = '0; stimWmsk = '0; stimWdata = '0; stimClear = 1'b0;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput("resetBusyA",   64'(ifA.o_busy),   64'd1);
    checkOutput("resetRvalidA", 64'(ifA.o_rvalid), 64'd0);
    checkOutput("resetRdataA",  ifA.o_rdata,       64'd0);
    checkOutput("resetRdataB",  ifB.o_rdata,       64'd0);
    checkOutput("resetBusyC",   64'(ifC.o_busy),   64'd1);

    // Clear after reset: busy for exactly WORDWD cycles, then all words read zero.
    @(posedge clock);
    #1;
    rstN = 1'b1;
    b0 = busyNeg[0]; b1 = busyNeg[1]; b2 = busyNeg[2];
    waitIdle(0);
    waitIdle(1);
    checkOutput("busyCyclesA", 64'(busyNeg[0] - b0), 64'd32);
    checkOutput("busyCyclesB", 64'(busyNeg[1] - b1), 64'd32);
    checkOutput("busyCyclesC", 64'(busyNeg[2] - b2), 64'd20);
    for (int a = 0; a < 32; a++) doRead(0, 5'(a), 64'd0);
    doIdle();

    // Masked writes, then an all-zero mask that must not change anything.
    doWrite(0, 5'd5, 2'b11, {32'hCCCC_DDDD, 32'hAAAA_BBBB});
    doWrite(0, 5'd5, 2'b01, {32'h9ABC_DEF0, 32'h1234_5678});
    doRead (0, 5'd5, {32'hCCCC_DEF0, 32'hAAAA_5678});
    doWrite(0, 5'd5, 2'b00, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    doRead (0, 5'd5, {32'hCCCC_DEF0, 32'hAAAA_5678});
    doIdle();

`ifdef RF_2P_BYPASS_EN
    collideExp = {32'h7777_6666, 32'h3333_2222};
`else
    collideExp = {32'h5555_6666, 32'h1111_2222};
`endif

    // Read-during-write collision and write-after-read on the 1-cycle instance.
    doWrite(0, 5'd7, 2'b11, {32'h5555_6666, 32'h1111_2222});
    doIdle();
    applyStimulus(0, 1'b1, 5'd7, 1'b1, 5'd7, 2'b10, {32'h7777_8888, 32'h3333_4444}, 1'b1, collideExp);
    doRead (0, 5'd7, {32'h7777_6666, 32'h3333_2222});
    doWrite(0, 5'd7, 2'b11, 64'd0);
    doRead (0, 5'd7, 64'd0);
    doIdle();

    // Two-cycle instance: fully pipelined back-to-back reads with per-channel data.
    doWrite(1, 5'd1, 2'b11, {32'h2000_0001, 32'h1000_0001});
    doWrite(1, 5'd2, 2'b11, {32'h2000_0002, 32'h1000_0002});
    doWrite(1, 5'd3, 2'b11, {32'h2000_0003, 32'h1000_0003});
    doRead (1, 5'd1, {32'h2000_0001, 32'h1000_0001});
    doRead (1, 5'd2, {32'h2000_0002, 32'h1000_0002});
    doRead (1, 5'd3, {32'h2000_0003, 32'h1000_0003});
    doIdle();

    // Collision and write-after-read on the 2-cycle instance.
    doWrite(1, 5'd7, 2'b11, {32'h5555_6666, 32'h1111_2222});
    applyStimulus(1, 1'b1, 5'd7, 1'b1, 5'd7, 2'b10, {32'h7777_8888, 32'h3333_4444}, 1'b1, collideExp);
    doRead (1, 5'd7, {32'h7777_6666, 32'h3333_2222});
    doWrite(1, 5'd7, 2'b11, 64'd0);
    doRead (1, 5'd7, 64'd0);
    doIdle();

    // Requested clear: traffic during busy is dropped and the word reads zero.
    doWrite(0, 5'd3, 2'b11, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    doRead (0, 5'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    b0 = busyNeg[0];
    doClear(0);
    applyStimulus(0, 1'b1, 5'd3, 1'b1, 5'd3, 2'b11, {32'h1234_5678, 32'h1234_5678}, 1'b0, 64'd0);
    doIdle();
    waitIdle(0);
    checkOutput("busyCyclesClearA", 64'(busyNeg[0] - b0), 64'd32);
    doRead(0, 5'd3, 64'd0);
    doIdle();

    // Reset in the middle of a clear restarts it; an in-flight read is dropped.
    b0 = busyNeg[0];
    doClear(0);
    doIdle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if ((busyNeg[0] - b0) >= 10) break;
    end
    applyStimulus(1, 1'b1, 5'd1, 1'b0, 5'd0, 2'b00, 64'd0, 1'b0, 64'd0);
    @(negedge clock);
    #1;
    rstN     = 1'b0;
    stimRead = 1'b0;
    @(posedge clock);
    #1;
    rstN = 1'b1;
    b0 = busyNeg[0]; b2 = busyNeg[2];
    waitIdle(0);
    checkOutput("busyCyclesMidResetA", 64'(busyNeg[0] - b0), 64'd32);
    checkOutput("busyCyclesMidResetC", 64'(busyNeg[2] - b2), 64'd20);
    doRead(1, 5'd1, 64'd0);
    doIdle();

    // Out-of-range addresses on the 20-word instance.
    waitIdle(2);
    doWrite(2, 5'd25, 2'b11, {32'hCAFE_F00D, 32'hDEAD_BEEF});
    doRead (2, 5'd25, 64'd0);
    doRead (2, 5'd5,  64'd0);
    doWrite(2, 5'd19, 2'b11, {32'h2468_ACE0, 32'h1357_9BDF});
    doRead (2, 5'd19, {32'h2468_ACE0, 32'h1357_9BDF});
    doIdle();

    repeat (6) @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput("pendingReadsA", 64'(qA.size()), 64'd0);
    checkOutput("pendingReadsB", 64'(qB.size()), 64'd0);
    checkOutput("pendingReadsC", 64'(qC.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

  // Watchdog: the sequence is bounded, this only catches a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
